// File: rtl/pillow_scheduler_if.sv
// Bus between the pillow scheduler and the renderer / collision side of the dodge game.
// The scheduler owns the row buses, so it sits on the master modport.
interface pillow_scheduler_if #(
  parameter int NUM_LANES = 9
);
  logic                     frame_tick;
  logic                     start;
  logic                     fail;
  logic [NUM_LANES*11-1:0]  begin_row;
  logic [NUM_LANES*11-1:0]  end_row;
  logic [NUM_LANES-1:0]     lane_active;
  logic                     gameover;
  logic [1:0]               state;
  logic [15:0]              score;
  logic [2:0]               level;

  modport master (
    input  frame_tick, start, fail,
    output begin_row, end_row, lane_active, gameover, state, score, level
  );

  modport slave (
    output frame_tick, start, fail,
    input  begin_row, end_row, lane_active, gameover, state, score, level
  );
endinterface

// File: rtl/pillow_scheduler.sv
// Run/freeze/over sequencer for the falling pillows: staggered lane spawns,
// per-frame row advance, retirement into score, level-based speed-up.
//
// state  | meaning
// IDLE   | waiting for first start press
// RUN    | pillows spawn and fall on each frame tick
// FREEZE | collision seen, picture held for FREEZE_FRAMES ticks
// OVER   | game over, waiting for start press to replay
module pillow_scheduler #(
  parameter int NUM_LANES     = 9,
  parameter int OBJ_H         = 80,
  parameter int SCREEN_H      = 480,
  parameter int SPAWN_GAP     = 30,
  parameter int FREEZE_FRAMES = 120
) (
  input  logic                VGA_CLK,
  input  logic                resetn,
  pillow_scheduler_if.master  bus
);
  localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int SW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int FW = $clog2(FREEZE_FRAMES + 1);
  localparam int RW = $clog2(NUM_LANES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FREEZE = 2'd2, OVER = 2'd3} state_t;

  state_t               state_q, state_d;
  logic                 start_q;
  logic [10:0]          row_q [NUM_LANES];
  logic [10:0]          row_d [NUM_LANES];
  logic [10:0]          end_q [NUM_LANES];
  logic [NUM_LANES-1:0] act_q, act_d;
  logic [15:0]          score_q, score_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [FW-1:0]        fcnt_q, fcnt_d;
  logic                 gameover_q;
  logic                 start_rise, spawn_hit;
  logic [2:0]           level_w;
  logic [10:0]          adv;
  logic [RW-1:0]        retired;
  logic [16:0]          score_sum;

  assign start_rise = bus.start & ~start_q;
  assign level_w    = (score_q[15:3] >= 13'd7) ? 3'd7 : score_q[5:3];

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    act_d     = act_q;
    score_d   = score_q;
    ptr_d     = ptr_q;
    scnt_d    = scnt_q;
    fcnt_d    = fcnt_q;
    spawn_hit = 1'b0;
    adv       = '0;
    retired   = '0;
    score_sum = '0;
    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          state_d = RUN;
          for (int i = 0; i < NUM_LANES; i++) row_d[i] = '0;
          act_d   = '0;
          score_d = '0;
          ptr_d   = '0;
          fcnt_d  = '0;
          scnt_d  = SW'(SPAWN_GAP - 1);
        end
      end
      RUN: begin
        if (bus.fail) begin
          state_d = FREEZE;
          fcnt_d  = '0;
        end else if (bus.frame_tick) begin
          spawn_hit = (scnt_q == SW'(SPAWN_GAP - 1));
          if (spawn_hit) begin
            scnt_d = '0;
            ptr_d  = (ptr_q == PW'(NUM_LANES - 1)) ? '0 : ptr_q + PW'(1);
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
          // Speed uses the level from before this tick's retirements.
          for (int i = 0; i < NUM_LANES; i++) begin
            if (act_q[i]) begin
              adv = row_q[i] + {8'd0, level_w} + 11'd1 + 11'(i % 3);
              if (adv >= 11'(SCREEN_H)) begin
                act_d[i] = 1'b0;
                row_d[i] = '0;
                retired  = retired + RW'(1);
              end else begin
                row_d[i] = adv;
              end
            end
          end
          if (spawn_hit && !act_q[ptr_q]) begin
            act_d[ptr_q] = 1'b1;
            row_d[ptr_q] = '0;
          end
          score_sum = {1'b0, score_q} + 17'(retired);
          score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
      end
      FREEZE: begin
        if (bus.frame_tick) begin
          fcnt_d = fcnt_q + FW'(1);
          if (fcnt_q == FW'(FREEZE_FRAMES - 1)) state_d = OVER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      act_q      <= '0;
      score_q    <= '0;
      ptr_q      <= '0;
      scnt_q     <= SW'(SPAWN_GAP - 1);
      fcnt_q     <= '0;
      gameover_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        row_q[i] <= '0;
        end_q[i] <= 11'(OBJ_H);
      end
    end else begin
      state_q    <= state_d;
      start_q    <= bus.start;
      act_q      <= act_d;
      score_q    <= score_d;
      ptr_q      <= ptr_d;
      scnt_q     <= scnt_d;
      fcnt_q     <= fcnt_d;
      gameover_q <= (state_d == FREEZE) || (state_d == OVER);
      for (int i = 0; i < NUM_LANES; i++) begin
        row_q[i] <= row_d[i];
        end_q[i] <= row_d[i] + 11'(OBJ_H);
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign bus.begin_row[11*g +: 11] = row_q[g];
    assign bus.end_row[11*g +: 11]   = end_q[g];
  end

  assign bus.lane_active = act_q;
  assign bus.gameover    = gameover_q;
  assign bus.state       = state_q;
  assign bus.score       = score_q;
  assign bus.level       = level_w;
endmodule
